// File: rtl/spi_master_if.sv
// Host-side handshake plus SPI pins of the mode-3 SPI master, bundled so the
// master and its bench/peripheral side connect through one port each.
interface spi_master_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic [DATA_W-1:0] txd_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rxd_data;
  logic              CS_N;
  logic              SCK;
  logic              MOSI;
  logic              MISO;

  modport master (
    input  start, txd_data, MISO,
    output busy, done, rxd_data, CS_N, SCK, MOSI
  );

  modport slave (
    output start, txd_data, MISO,
    input  busy, done, rxd_data, CS_N, SCK, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// SPI master, mode 3 (CPOL=1, CPHA=1), one fixed-length word per CS_N frame.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first in both directions (default MSB-first).
module spi_master #(
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ?
                           ((CLK_DIV > CS_HOLD) ? ((CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE)
                                                : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE)) :
                           ((CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                                                 : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE));
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rxd_q, rxd_d;
  logic              cs_n_q, cs_n_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tx_first;
  logic [DATA_W-1:0] tx_shifted;
  logic [DATA_W-1:0] rx_shifted;

  // Bit order only changes which end of the shifters is used.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign tx_first   = tx_q[0];
  assign tx_shifted = {1'b0, tx_q[DATA_W-1:1]};
  assign rx_shifted = {bus.MISO, rx_q[DATA_W-1:1]};
`else
  assign tx_first   = tx_q[DATA_W-1];
  assign tx_shifted = {tx_q[DATA_W-2:0], 1'b0};
  assign rx_shifted = {rx_q[DATA_W-2:0], bus.MISO};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rxd_q     <= '0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rxd_q     <= rxd_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rxd_d     = rxd_q;
    cs_n_d    = cs_n_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tx_d    = bus.txd_data;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d     = '0;
          sck_d     = 1'b0;
          mosi_d    = tx_first;
          tx_d      = tx_shifted;
          bit_cnt_d = '0;
          state_d   = S_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // MISO is taken on the same clk edge that raises SCK.
      S_LOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          rx_d    = rx_shifted;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = S_HOLD;
          end else begin
            sck_d     = 1'b0;
            mosi_d    = tx_first;
            tx_d      = tx_shifted;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            state_d   = S_LOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          rxd_d   = rx_q;
          done_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == IDLE_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.CS_N     = cs_n_q;
  assign bus.SCK      = sck_q;
  assign bus.MOSI     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rxd_data = rxd_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback and mode-3 slave model, latency,
// busy/done timing, ignored starts, back-to-back words and mid-word reset.
module tb_spi_master;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  spi_master_if #(.DATA_W(DW)) sif ();

  spi_master #(
    .DATA_W  (DW),
    .CLK_DIV (4),
    .CS_SETUP(2),
    .CS_HOLD (2),
    .CS_IDLE (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mode-3 slave model: shifts MISO out on SCK fall, captures MOSI on SCK rise.
  logic          loop_en     = 1'b1;
  logic [DW-1:0] slave_word  = '0;
  logic [DW-1:0] slave_sh    = '0;
  logic [DW-1:0] slave_cap   = '0;
  logic          slave_miso  = 1'b0;
  int            slave_rises = 0;
  int            sck_bad     = 0;
  int            done_cnt    = 0;

  assign sif.MISO = loop_en ? sif.MOSI : slave_miso;

  always @(negedge sif.CS_N) begin
    slave_sh    <= slave_word;
    slave_cap   <= '0;
    slave_rises <= 0;
  end

  always @(negedge sif.SCK) begin
    if (sif.CS_N === 1'b0) begin
      slave_miso <= slave_sh[DW-1];
      slave_sh   <= {slave_sh[DW-2:0], 1'b0};
    end
  end

  always @(posedge sif.SCK) begin
    if (sif.CS_N === 1'b0) begin
      slave_cap   <= {slave_cap[DW-2:0], sif.MOSI};
      slave_rises <= slave_rises + 1;
    end
  end

  always @(sif.SCK) begin
    if (rst_n && sif.CS_N === 1'b1) sck_bad <= sck_bad + 1;
  end

  always @(negedge clk) begin
    if (sif.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int acc_cyc;

  task automatic send(input logic [DW-1:0] tx);
    @(negedge clk);
    sif.start    = 1'b1;
    sif.txd_data = tx;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    sif.start = 1'b0;
  endtask

  task automatic wait_done(output int dcyc, output logic [DW-1:0] rx);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (sif.done !== 1'b1 && i < 400);
    if (sif.done !== 1'b1) begin
      check("done_timeout", 32'd0, 32'd1);
      dcyc = -1;
    end else begin
      dcyc = cyc;
    end
    rx = sif.rxd_data;
    $display("word: accept@%0d done@%0d rxd=%h slave_cap=%h rises=%0d",
             acc_cyc, dcyc, rx, slave_cap, slave_rises);
  endtask

`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam logic [DW-1:0] EXP_CAP_A5C3 = 16'hC3A5;
  localparam logic [DW-1:0] EXP_RX_1234  = 16'h2C48;
  localparam logic [DW-1:0] EXP_CAP_BEEF = 16'hF77D;
`else
  localparam logic [DW-1:0] EXP_CAP_A5C3 = 16'hA5C3;
  localparam logic [DW-1:0] EXP_RX_1234  = 16'h1234;
  localparam logic [DW-1:0] EXP_CAP_BEEF = 16'hBEEF;
`endif

  initial begin
    int            d1, d2, g, dc;
    logic [DW-1:0] r1, r2;

    sif.start    = 1'b0;
    sif.txd_data = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", sif.CS_N, 1);
    check("rst_sck", sif.SCK, 1);
    check("rst_mosi", sif.MOSI, 0);
    check("rst_busy", sif.busy, 0);
    check("rst_done", sif.done, 0);
    check("rst_rxd", sif.rxd_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback, latency and busy/done timing
    loop_en = 1'b1;
    send(16'hA5C3);
    check("busy_after_accept", sif.busy, 1);
    wait_done(d1, r1);
    check("lat_a5c3", d1 - acc_cyc, 132);
    check("rx_a5c3", r1, 16'hA5C3);
    check("rises_a5c3", slave_rises, 16);
    check("cap_a5c3", slave_cap, EXP_CAP_A5C3);
`ifndef SPI_MASTER_LSB_FIRST_EN
    check("first_bit_a5c3", slave_cap[15], 1);
    check("second_bit_a5c3", slave_cap[14], 0);
`endif
    check("cs_at_done", sif.CS_N, 1);
    check("busy_at_done", sif.busy, 1);
    @(negedge clk);
    check("done_width", sif.done, 0);
    check("busy_done_p1", sif.busy, 1);
    @(negedge clk);
    check("busy_done_p2", sif.busy, 0);
    repeat (2) @(negedge clk);

    // Mode-3 slave model
    loop_en    = 1'b0;
    slave_word = 16'h1234;
    send(16'hBEEF);
    wait_done(d1, r1);
    check("rx_slave", r1, EXP_RX_1234);
    check("cap_beef", slave_cap, EXP_CAP_BEEF);
    repeat (4) @(negedge clk);

    // start while busy is ignored; txd changes mid-word ignored
    loop_en = 1'b1;
    dc      = done_cnt;
    send(16'h1111);
    repeat (9) @(negedge clk);
    sif.start    = 1'b1;
    sif.txd_data = 16'h2222;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (49) @(negedge clk);
    sif.start    = 1'b1;
    sif.txd_data = 16'h3333;
    @(negedge clk);
    sif.start = 1'b0;
    wait_done(d1, r1);
    check("rx_ignored_start", r1, 16'h1111);
    repeat (20) @(negedge clk);
    check("one_done_only", done_cnt - dc, 1);
    check("idle_after_ignore", sif.busy, 0);

    // start held high: back-to-back words
    @(negedge clk);
    sif.start    = 1'b1;
    sif.txd_data = 16'h0001;
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    sif.txd_data = 16'h8000;
    wait_done(d1, r1);
    g = 0;
    while (sif.CS_N === 1'b1 && g < 20) begin
      g++;
      @(negedge clk);
    end
    sif.start = 1'b0;
    check("cs_gap", g, 3);
    acc_cyc = cyc;
    wait_done(d2, r2);
    check("rx_word1", r1, 16'h0001);
    check("rx_word2", r2, 16'h8000);
    check("done_spacing", d2 - d1, 135);
    repeat (4) @(negedge clk);
    check("no_sck_while_cs_high", sck_bad, 0);

`ifdef SPI_MASTER_LSB_FIRST_EN
    send(16'h00F1);
    wait_done(d1, r1);
    check("rx_00f1", r1, 16'h00F1);
    check("cap_00f1", slave_cap, 16'h8F00);
    check("first_bit_00f1", slave_cap[15], 1);
    check("second_bit_00f1", slave_cap[14], 0);
    repeat (4) @(negedge clk);
`endif

    // Reset in the middle of a word
    dc = done_cnt;
    send(16'h5A5A);
    repeat (49) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", sif.CS_N, 1);
    check("midrst_sck", sif.SCK, 1);
    check("midrst_mosi", sif.MOSI, 0);
    check("midrst_busy", sif.busy, 0);
    check("midrst_rxd", sif.rxd_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check("midrst_no_done", done_cnt - dc, 0);
    check("midrst_rxd_held", sif.rxd_data, 0);
    send(16'h3C5A);
    wait_done(d1, r1);
    check("lat_after_rst", d1 - acc_cyc, 132);
    check("rx_after_rst", r1, 16'h3C5A);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
